// File: rtl/tsm_pkg.sv
// Shared types and helpers for the toggle stream monitor.
package tsm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // All-ones value of a width-bit counter, used as the saturation ceiling.
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/tsm_edge_detect.sv
// Toggle detector for the q stream. Defining TSM_SYNC_EN inserts a 2-flop
// synchronizer ahead of detection for a q_in from another clock domain.
module tsm_edge_detect (
  input  logic clk,
  input  logic re,
  input  logic q_in,
  output logic toggle,
  output logic edge_pulse
);

  logic q_d;
  logic q_s;

`ifdef TSM_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge re) begin
    if (!re) sync <= '0;
    else     sync <= {sync[0], q_in};
  end

  assign q_d = sync[1];
`else
  assign q_d = q_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      q_s        <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      q_s        <= q_d;
      edge_pulse <= toggle;
    end
  end

  assign toggle = (q_d != q_s);

endmodule

// File: rtl/toggle_stream_monitor.sv
// Counts q_in toggles over back-to-back WIN_LEN-cycle windows and hands each
// count to a valid/ready consumer. Optional input synchronizer: TSM_SYNC_EN.
module toggle_stream_monitor
  import tsm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             re,
  input  logic             start,
  input  logic             stop,
  input  logic             q_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int               WIN_W    = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   tog_cnt;
  logic [CNT_W-1:0]   tog_next;
  logic               toggle;
  logic               close;
  logic               xfer;

  tsm_edge_detect u_edge (
    .clk        (clk),
    .re         (re),
    .q_in       (q_in),
    .toggle     (toggle),
    .edge_pulse (edge_pulse)
  );

  assign tog_next = (toggle && (tog_cnt != CNT_MAX)) ? tog_cnt + CNT_W'(1) : tog_cnt;
  assign close    = (state == MEASURE) && (win_cnt == WIN_LAST);
  assign xfer     = cnt_valid && cnt_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state     <= IDLE;
      win_cnt   <= '0;
      tog_cnt   <= '0;
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // An accepted result drops valid unless a window close re-raises it below.
      if (xfer) cnt_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= MEASURE;
            win_cnt <= '0;
            tog_cnt <= '0;
            overrun <= 1'b0;
          end
        end

        MEASURE: begin
          if (close) begin
            cnt_data  <= tog_next;
            cnt_valid <= 1'b1;
            if (cnt_valid && !cnt_ready) overrun <= 1'b1;
            win_cnt   <= '0;
            tog_cnt   <= '0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            tog_cnt <= tog_next;
          end

          // Partial window is dropped; linger in DRAIN only while a result is
          // still owed to the consumer after this cycle.
          if (stop) begin
            win_cnt <= '0;
            tog_cnt <= '0;
            state   <= (close || (cnt_valid && !cnt_ready)) ? DRAIN : IDLE;
          end
        end

        DRAIN: begin
          if (xfer) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/toggle_stream_monitor.md
Name: toggle_stream_monitor

Overview:
- Sits directly downstream of the T flip-flop stage and consumes its q output.
- Detects every toggle of q and counts toggles over fixed windows of WIN_LEN clocks.
- Presents each window's count to a consumer over a valid/ready handshake.
- Flags an overrun when a result is overwritten before the consumer accepts it.

Parameters:
- CNT_W, 8: width of toggle count and result.
- WIN_LEN, 16: measurement window length in clk cycles (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- re  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: begin continuous measurement.
- stop  in  1  one-cycle pulse: end measurement.
- q_in  in  1  toggle stream from the TFF stage.
- edge_pulse  out  1  one-cycle strobe per detected toggle.
- cnt_data  out  CNT_W  toggle count of the last completed window.
- cnt_valid  out  1  cnt_data holds an unaccepted result.
- cnt_ready  in  1  consumer accepts cnt_data.
- overrun  out  1  sticky: a result was overwritten unaccepted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (re=0, async):
  - State=IDLE; q_s, edge_pulse, cnt_data, cnt_valid, overrun and internal counters all 0.
- Edge detect, active in all states:
  - q_s <= q_in every cycle.
  - edge = (q_in != q_s).
  - edge_pulse <= edge (latency 1 cycle).
- FSM states: IDLE, MEASURE, DRAIN.
  - IDLE: start=1 and stop=0 -> MEASURE; clear win_cnt, tog_cnt, overrun. start and stop together -> stay IDLE.
  - MEASURE:
    - win_cnt counts 0..WIN_LEN-1.
    - tog_cnt += edge, saturating at 2^CNT_W-1.
    - Window closes when win_cnt==WIN_LEN-1. On close: cnt_data <= tog_cnt + edge (saturated); cnt_valid <= 1; win_cnt <= 0; tog_cnt <= 0. The next window starts immediately with no gap.
    - stop=1: discard the partial window. Go to DRAIN if cnt_valid=1, else IDLE.
    - stop coinciding with a window close: the close takes effect, then go to DRAIN.
  - DRAIN: wait for the handshake, then IDLE. start is ignored here.
- Handshake:
  - Transfer occurs when cnt_valid && cnt_ready.
  - cnt_valid clears the next cycle, unless a window closes in the same cycle. In that case cnt_valid stays 1 with the new data and no overrun.
  - Window close while cnt_valid=1 and cnt_ready=0: overrun <= 1 (sticky), cnt_data overwritten.
  - cnt_data is stable while cnt_valid=1 and no close occurs.
- overrun clears only on reset or an accepted start.
- Timing: start sampled at cycle 0, MEASURE covers cycles 1..WIN_LEN, cnt_valid first high at cycle WIN_LEN+1.
- Reset mid-operation: immediate return to reset values. Any pending result is lost.

Optional Feature:
- Macro TSM_SYNC_EN.
- Defined: q_in passes through a 2-flop synchronizer (reset 0) before edge detect. Edge latency becomes 3 cycles; window alignment is unchanged and counts shift by the 2-cycle delay.
- Undefined: q_in feeds edge detect directly (same-clock-domain TFF).

Decomposition:
- Package tsm_pkg:
  - state encoding constants IDLE=2'd0, MEASURE=2'd1, DRAIN=2'd2;
  - saturation max function/constant derived from CNT_W.
- One sub-module: tsm_edge_detect. It holds the optional synchronizer, q_s, edge and edge_pulse.

Test Plan (CNT_W=8, WIN_LEN=16 unless stated):
1. re=0 with q_in toggling -> all outputs 0, busy=0. Release re, no start -> cnt_valid never rises.
2. q_in=0 constant, start, cnt_ready=1 -> cnt_valid at cycle 17 with cnt_data=0, then every 16 cycles.
3. q_in toggles every 2 cycles, cnt_ready=1 -> each cnt_data=8, edge_pulse 1 cycle after each q_in change.
4. cnt_ready=0 across two closes -> overrun=1 after the second close, cnt_data=second window's value. A new start clears overrun.
5. CNT_W=4, WIN_LEN=32, q_in toggling every cycle -> cnt_data=15 (saturated).
6. stop mid-window with cnt_valid=1, cnt_ready=0 -> DRAIN, busy=1. cnt_ready=1 -> transfer, then IDLE, busy=0, partial count never presented.
